// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_fd_sc_mcu7t5v0__pkg
// Description : Shared helpers for the 7-track 5 V library filtered cells.
//               Holds a constant clog2 for sizing counters and the legal
//               parameter-range check used at elaboration time.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gf180mcu_fd_sc_mcu7t5v0__pkg;

    // Ceiling log2. Callers pass a value of at least 2, so the result is at least 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Legal ranges of the norn_filt parameters.
    function automatic bit norn_filt_params_legal(input int n,
                                                  input int depth,
                                                  input int sync_stages);
        return (n >= 2) && (n <= 16) &&
               (depth >= 1) && (depth <= 255) &&
               (sync_stages >= 2) && (sync_stages <= 3);
    endfunction

endpackage : gf180mcu_fd_sc_mcu7t5v0__pkg
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sync_rn.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_fd_sc_mcu7t5v0__sync_rn
// Description : One-bit multi-flop synchroniser with asynchronous active-low
//               clear. All stages reset to 0.
// Ports       : CLK - rising-edge clock
//               RN  - asynchronous active-low reset
//               D   - asynchronous input bit
//               Q   - synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__sync_rn
    import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] r_chain;

    // Bit 0 is the metastability-catching stage; the MSB is the clean output.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], D};
        end
    end

    assign Q = r_chain[STAGES-1];

endmodule : gf180mcu_fd_sc_mcu7t5v0__sync_rn
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_filt.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_fd_sc_mcu7t5v0__norn_filt
// Description : N-input NOR with per-input synchronisers and a symmetric
//               persistence filter. ZN only changes after the synchronised
//               NOR has disagreed with it for DEPTH consecutive enabled
//               cycles; RISE/FALL pulse for one cycle on each change.
// Ports       : CLK  - rising-edge clock
//               RN   - asynchronous active-low reset
//               A    - N asynchronous active-high inputs
//               EN   - filter enable (0: ZN frozen, counter cleared)
//               ZN   - filtered NOR of A, resets to 1
//               RISE - one-cycle pulse on ZN 0->1
//               FALL - one-cycle pulse on ZN 1->0
//               VDD  - supply
//               VSS  - ground
// Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__norn_filt
    import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
    parameter int N           = 3,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic [N-1:0] A,
    input  logic         EN,
    output logic         ZN,
    output logic         RISE,
    output logic         FALL,
    inout  wire          VDD,
    inout  wire          VSS
);

    localparam int CNT_W = clog2(DEPTH + 1);

    // Filter state is ZN itself.
    localparam logic [0:0]       c_st_idle_low  = 1'b0;
    localparam logic [0:0]       c_st_idle_high = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_last     = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    if (!norn_filt_params_legal(N, DEPTH, SYNC_STAGES)) begin : g_param_error
        $error("norn_filt: illegal parameters N=%0d DEPTH=%0d SYNC_STAGES=%0d",
               N, DEPTH, SYNC_STAGES);
    end

    logic [N-1:0]     w_sync;
    logic             w_nor_s;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    // Supply pins exist for the library netlist only; no logic depends on them.
    wire w_unused_supply = &{1'b0, VDD, VSS};

    for (genvar i = 0; i < N; i++) begin : g_sync
        gf180mcu_fd_sc_mcu7t5v0__sync_rn #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .CLK (CLK),
            .RN  (RN),
            .D   (A[i]),
            .Q   (w_sync[i])
        );
    end

    assign w_nor_s = ~|w_sync;

    // Any agreeing cycle (or EN low) discards accumulated disagreement, so the
    // counter only ever climbs to DEPTH-1 before it is either cleared or the
    // state flips; it cannot wrap.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= c_st_idle_high;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!EN) begin
                r_cnt <= '0;
            end else if (w_nor_s == r_state[0]) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_state <= w_nor_s ? c_st_idle_high : c_st_idle_low;
                r_cnt   <= '0;
                r_rise  <= w_nor_s;
                r_fall  <= ~w_nor_s;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign ZN   = r_state[0];
    assign RISE = r_rise;
    assign FALL = r_fall;

endmodule : gf180mcu_fd_sc_mcu7t5v0__norn_filt
`default_nettype wire
